// File: rtl/wb_csr_bank.sv
// Wishbone B3 slave exposing NUM_REGS 32-bit CSRs whose bits are individually typed
// RW / SC / W1C / RO, with a registered single-beat response, sticky events and an irq.
module wb_csr_bank #(
  parameter int unsigned                NUM_REGS  = 4,
  parameter logic [31:0]                ADR_BASE  = 32'h8000_0000,
  parameter logic [31:0]                ADR_MASK  = 32'hFFFF_FF00,
  parameter logic [NUM_REGS*32-1:0]     RW_MASK   = {32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0000_0002},
  parameter logic [NUM_REGS*32-1:0]     SC_MASK   = {32'h0, 32'h0, 32'h0, 32'h0000_0001},
  parameter logic [NUM_REGS*32-1:0]     W1C_MASK  = {32'h0, 32'h0000_00FF, 32'h0, 32'h0},
  parameter logic [NUM_REGS*32-1:0]     RO_MASK   = {32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0},
  parameter logic [NUM_REGS*32-1:0]     RESET_VAL = '0
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [31:0]              wb_adr_i,
  input  logic [3:0]               wb_sel_i,
  input  logic [31:0]              wb_dat_i,
  input  logic [2:0]               wb_cti_i,
  input  logic [1:0]               wb_bte_i,
  output logic [31:0]              wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic                     wb_rty_o,
  input  logic [NUM_REGS*32-1:0]   status_i,
  input  logic [NUM_REGS*32-1:0]   event_i,
  output logic [NUM_REGS*32-1:0]   ctrl_o,
  output logic                     irq_o
);

  localparam int unsigned   DW      = NUM_REGS * 32;
  localparam int unsigned   IDXW    = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;
  localparam logic [DW-1:0] ST_MASK = RW_MASK | SC_MASK | W1C_MASK;
  localparam logic [DW-1:0] OVL     = (RW_MASK & SC_MASK) | (RW_MASK & W1C_MASK) | (RW_MASK & RO_MASK)
                                    | (SC_MASK & W1C_MASK) | (SC_MASK & RO_MASK) | (W1C_MASK & RO_MASK);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t           r_state, w_state_nxt;
  logic             w_accept;
  logic             w_hit, w_req, w_bad, w_wr, w_rd;
  logic [29:0]      w_word;
  logic [IDXW-1:0]  w_idx;
  logic [31:0]      w_bmask;
  logic [31:0]      w_rd_word;
  logic [DW-1:0]    w_wsel, w_wdat, w_reg_nxt;
  logic [DW-1:0]    r_reg;
  logic             r_ack, r_err, r_irq;
  logic [31:0]      r_dat;
  logic             w_unused;

  // Full in-window word offset catches out-of-range indices that alias onto idx bits.
  assign w_hit  = (wb_adr_i & ADR_MASK) == ADR_BASE;
  assign w_req  = wb_cyc_i & wb_stb_i & w_hit;
  assign w_word = wb_adr_i[31:2] & ~ADR_MASK[31:2];
  assign w_idx  = wb_adr_i[IDXW+1:2];
  assign w_bad  = (w_word >= 30'(NUM_REGS)) || !((wb_cti_i == 3'b000) || (wb_cti_i == 3'b111));
  assign w_wr   = w_accept & wb_we_i & ~w_bad;
  assign w_rd   = w_accept & ~wb_we_i & ~w_bad;
  assign w_unused = ^{wb_bte_i, wb_adr_i[1:0]};

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: if (w_req) begin
        w_accept    = 1'b1;
        w_state_nxt = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Lane write mask placed on the addressed register, plus read mux.
  always_comb begin
    w_wsel    = '0;
    w_rd_word = '0;
    for (int b = 0; b < 4; b++) w_bmask[b*8 +: 8] = {8{wb_sel_i[b]}};
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (w_idx == IDXW'(i)) begin
        w_rd_word = (r_reg[i*32 +: 32] & ST_MASK[i*32 +: 32]) | (status_i[i*32 +: 32] & RO_MASK[i*32 +: 32]);
        if (w_wr) w_wsel[i*32 +: 32] = w_bmask;
      end
    end
  end

  // RW holds unless written, SC falls back to 0, W1C clears on written 1 and events win.
  assign w_wdat    = {NUM_REGS{wb_dat_i}};
  assign w_reg_nxt = ((RW_MASK | SC_MASK) & ((w_wsel & w_wdat) | (~w_wsel & r_reg & RW_MASK)))
                   | (W1C_MASK & ((r_reg & ~(w_wsel & w_wdat)) | event_i));

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_reg <= RESET_VAL & ST_MASK;
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
      r_irq <= 1'b0;
    end else begin
      r_reg <= w_reg_nxt;
      r_ack <= w_accept & ~w_bad;
      r_err <= w_accept & w_bad;
      r_dat <= w_rd ? w_rd_word : 32'h0;
      r_irq <= |(r_reg & W1C_MASK);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    assert (OVL == '0) else $error("wb_csr_bank: bit-type masks overlap");
  end

  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign wb_dat_o = r_dat;
  assign wb_rty_o = 1'b0;
  assign ctrl_o   = r_reg;
  assign irq_o    = r_irq;

endmodule

// File: tb/tb_wb_csr_bank.sv
// Self-checking bench for wb_csr_bank: directed scenarios plus randomized traffic
// compared every cycle against a bit-level behavioural model.
module tb_wb_csr_bank;

  localparam int NR = 4;
  localparam logic [31:0]  ABASE = 32'h8000_0000;
  localparam logic [31:0]  AMASK = 32'hFFFF_FF00;
  localparam logic [127:0] RW  = {32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0000_0002};
  localparam logic [127:0] SC  = {32'h0, 32'h0, 32'h0, 32'h0000_0001};
  localparam logic [127:0] W1C = {32'h0, 32'h0000_00FF, 32'h0, 32'h0};
  localparam logic [127:0] RO  = {32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0]  wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]   wb_sel_i;
  logic [2:0]   wb_cti_i;
  logic [1:0]   wb_bte_i;
  logic         wb_ack_o, wb_err_o, wb_rty_o, irq_o;
  logic [127:0] status_i, event_i, ctrl_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic bg = 1'b0;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  wb_csr_bank dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .status_i(status_i), .event_i(event_i),
    .ctrl_o(ctrl_o), .irq_o(irq_o)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: per-bit rules evaluated at each clock edge.
  logic [127:0] m_ctrl;
  logic         m_busy, exp_ack, exp_err, exp_irq;
  logic [31:0]  exp_dat;

  always @(posedge clk or negedge rst_n) begin : model
    logic [127:0] cur, nxt;
    logic [31:0]  off, d;
    logic         acc, bad, a, e;
    int           w, k;
    if (!rst_n) begin
      m_ctrl <= '0; m_busy <= 1'b0; exp_ack <= 1'b0; exp_err <= 1'b0;
      exp_dat <= '0; exp_irq <= 1'b0;
    end else begin
      cur = m_ctrl;
      nxt = cur & ~SC;
      a = 1'b0; e = 1'b0; d = '0;
      acc = !m_busy && wb_cyc_i && wb_stb_i && ((wb_adr_i & AMASK) == ABASE);
      if (acc) begin
        off = wb_adr_i & ~AMASK;
        w   = int'(off >> 2);
        bad = (w >= NR) || !(wb_cti_i == 3'b000 || wb_cti_i == 3'b111);
        if (bad) e = 1'b1;
        else begin
          a = 1'b1;
          for (int b = 0; b < 32; b++) begin
            k = w * 32 + b;
            if (wb_we_i) begin
              if (wb_sel_i[b/8]) begin
                if (RW[k] || SC[k]) nxt[k] = wb_dat_i[b];
                if (W1C[k] && wb_dat_i[b]) nxt[k] = 1'b0;
              end
            end else begin
              d[b] = RO[k] ? status_i[k] : cur[k];
            end
          end
        end
      end
      nxt = nxt | (event_i & W1C);
      m_ctrl  <= nxt;
      m_busy  <= acc;
      exp_ack <= a;
      exp_err <= e;
      exp_dat <= d;
      exp_irq <= |(cur & W1C);
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      check_eq("ack", wb_ack_o, exp_ack);
      check_eq("err", wb_err_o, exp_err);
      check_eq("dat", wb_dat_o, exp_dat);
      check_eq("ctrl", ctrl_o, m_ctrl);
      check_eq("irq", irq_o, exp_irq);
      check_eq("rty", wb_rty_o, 1'b0);
    end
  end

  initial forever begin
    @(negedge clk);
    if (bg) begin
      status_i = {$urandom, $urandom, $urandom, $urandom};
      event_i  = {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom,
                  $urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
    end
  end

  logic         t_ack, t_err, t_irq_r, t_irq_n;
  logic [31:0]  t_rd;
  logic [127:0] t_cr, t_cn;

  task automatic bus(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                     input logic [31:0] dat, input logic [2:0] cti, input logic [127:0] ev,
                     output logic ack, output logic err, output logic [31:0] rd,
                     output logic [127:0] c_resp, output logic [127:0] c_next,
                     output logic irq_resp, output logic irq_next);
    @(negedge clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr;
    wb_sel_i = sel; wb_dat_i = dat; wb_cti_i = cti; wb_bte_i = 2'($urandom);
    if (!bg) event_i = ev;
    @(posedge clk); #1;
    ack = wb_ack_o; err = wb_err_o; rd = wb_dat_o; c_resp = ctrl_o; irq_resp = irq_o;
    @(negedge clk);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    if (!bg) event_i = '0;
    @(posedge clk); #1;
    check_eq("resp_one_cycle", {wb_ack_o, wb_err_o}, 2'b00);
    c_next = ctrl_o; irq_next = irq_o;
  endtask

  logic [31:0] r_adr;
  logic [2:0]  r_cti;
  int          gap;

  initial begin
    rst_n = 1'b0; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = '0;
    wb_sel_i = '0; wb_dat_i = '0; wb_cti_i = '0; wb_bte_i = '0;
    status_i = '0; event_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; chk_on = 1'b1;
    check_eq("rst_ack", wb_ack_o, 1'b0);
    check_eq("rst_err", wb_err_o, 1'b0);
    check_eq("rst_dat", wb_dat_o, 32'h0);
    check_eq("rst_ctrl", ctrl_o, 128'h0);
    check_eq("rst_irq", irq_o, 1'b0);

    // Byte-lane write to scratch.
    bus(1, ABASE + 32'h4, 4'b0101, 32'hA5A5_A5A5, 3'b000, '0, t_ack, t_err, t_rd, t_cr, t_cn, t_irq_r, t_irq_n);
    check_eq("wr1_ack", {t_ack, t_err}, 2'b10);
    bus(0, ABASE + 32'h4, 4'b0000, 32'h0, 3'b000, '0, t_ack, t_err, t_rd, t_cr, t_cn, t_irq_r, t_irq_n);
    check_eq("rd1_ack", {t_ack, t_err}, 2'b10);
    check_eq("rd1_dat", t_rd, 32'h00A5_00A5);

    // Self-clearing flush pulse beside sticky enable.
    bus(1, ABASE, 4'hF, 32'h3, 3'b111, '0, t_ack, t_err, t_rd, t_cr, t_cn, t_irq_r, t_irq_n);
    check_eq("sc_pulse", t_cr[1:0], 2'b11);
    check_eq("sc_clear", t_cn[1:0], 2'b10);
    bus(0, ABASE, 4'hF, 32'h0, 3'b000, '0, t_ack, t_err, t_rd, t_cr, t_cn, t_irq_r, t_irq_n);
    check_eq("rd0_dat", t_rd, 32'h2);

    // Sticky events and interrupt.
    @(negedge clk); event_i[67] = 1'b1;
    @(negedge clk); event_i[67] = 1'b0;
    bus(0, ABASE + 32'h8, 4'hF, 32'h0, 3'b000, '0, t_ack, t_err, t_rd, t_cr, t_cn, t_irq_r, t_irq_n);
    check_eq("ev_dat", t_rd, 32'h8);
    check_eq("ev_irq", t_irq_r, 1'b1);
    bus(1, ABASE + 32'h8, 4'hF, 32'h8, 3'b000, 128'h1 << 67, t_ack, t_err, t_rd, t_cr, t_cn, t_irq_r, t_irq_n);
    check_eq("ev_beats_clr", t_cr[67], 1'b1);
    bus(1, ABASE + 32'h8, 4'hF, 32'h8, 3'b000, '0, t_ack, t_err, t_rd, t_cr, t_cn, t_irq_r, t_irq_n);
    check_eq("w1c_clr", t_cr[67], 1'b0);
    check_eq("irq_lag", t_irq_r, 1'b1);
    check_eq("irq_drop", t_irq_n, 1'b0);

    // Read-only status.
    status_i[127:96] = 32'hDEAD_BEEF;
    bus(0, ABASE + 32'hC, 4'h1, 32'h0, 3'b000, '0, t_ack, t_err, t_rd, t_cr, t_cn, t_irq_r, t_irq_n);
    check_eq("ro_dat", t_rd, 32'hDEAD_BEEF);
    bus(1, ABASE + 32'hC, 4'hF, 32'h0, 3'b000, '0, t_ack, t_err, t_rd, t_cr, t_cn, t_irq_r, t_irq_n);
    check_eq("ro_wr_ack", {t_ack, t_err}, 2'b10);
    bus(0, ABASE + 32'hC, 4'hF, 32'h0, 3'b000, '0, t_ack, t_err, t_rd, t_cr, t_cn, t_irq_r, t_irq_n);
    check_eq("ro_dat2", t_rd, 32'hDEAD_BEEF);

    // Error and non-hit cases.
    bus(1, ABASE + 32'h10, 4'hF, 32'hFFFF_FFFF, 3'b000, '0, t_ack, t_err, t_rd, t_cr, t_cn, t_irq_r, t_irq_n);
    check_eq("err_idx", {t_ack, t_err}, 2'b01);
    bus(0, ABASE + 32'h10, 4'hF, 32'h0, 3'b000, '0, t_ack, t_err, t_rd, t_cr, t_cn, t_irq_r, t_irq_n);
    check_eq("err_idx_rd", {t_ack, t_err}, 2'b01);
    check_eq("err_idx_dat", t_rd, 32'h0);
    bus(1, ABASE, 4'hF, 32'h0, 3'b010, '0, t_ack, t_err, t_rd, t_cr, t_cn, t_irq_r, t_irq_n);
    check_eq("err_cti", {t_ack, t_err}, 2'b01);
    bus(0, ABASE, 4'hF, 32'h0, 3'b000, '0, t_ack, t_err, t_rd, t_cr, t_cn, t_irq_r, t_irq_n);
    check_eq("err_nochg", t_rd, 32'h2);
    bus(1, 32'h9000_0000, 4'hF, 32'h1, 3'b000, '0, t_ack, t_err, t_rd, t_cr, t_cn, t_irq_r, t_irq_n);
    check_eq("nohit", {t_ack, t_err}, 2'b00);

    // Reset during the response cycle.
    @(negedge clk);
    wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0; wb_adr_i = ABASE + 32'h4; wb_sel_i = 4'hF; wb_cti_i = 3'b000;
    @(posedge clk); #1;
    check_eq("rst_mid_pre", {wb_ack_o, wb_dat_o}, {1'b1, 32'h00A5_00A5});
    #2 rst_n = 1'b0; #1;
    check_eq("rst_mid_ack", {wb_ack_o, wb_err_o}, 2'b00);
    check_eq("rst_mid_dat", wb_dat_o, 32'h0);
    @(negedge clk); wb_cyc_i = 0; wb_stb_i = 0;
    @(negedge clk); rst_n = 1'b1;
    check_eq("rst_mid_ctrl", ctrl_o, 128'h0);
    bus(0, ABASE, 4'hF, 32'h0, 3'b000, '0, t_ack, t_err, t_rd, t_cr, t_cn, t_irq_r, t_irq_n);
    check_eq("post_rst_rd0", {t_ack, t_err, t_rd}, {2'b10, 32'h0});

    // Randomized traffic against the model.
    bg = 1'b1;
    for (int t = 0; t < 400; t++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      case ($urandom_range(0, 7))
        0, 1, 2, 3: r_adr = ABASE + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
        4:          r_adr = ABASE + 32'h10 + 32'($urandom_range(0, 58) * 4);
        5:          r_adr = 32'h9000_0000 + 32'($urandom_range(0, 15) * 4);
        6:          r_adr = ABASE + 32'($urandom_range(0, 255));
        default:    r_adr = ABASE + 32'($urandom_range(0, 3) * 4);
      endcase
      case ($urandom_range(0, 9))
        0, 1:    r_cti = 3'b111;
        2:       r_cti = 3'($urandom);
        default: r_cti = 3'b000;
      endcase
      bus(1'($urandom), r_adr, 4'($urandom), $urandom, r_cti, '0,
          t_ack, t_err, t_rd, t_cr, t_cn, t_irq_r, t_irq_n);
    end
    bg = 1'b0;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_csr_bank.md
Name: wb_csr_bank

Overview:
- Parametrised Wishbone B3 slave holding NUM_REGS memory-mapped 32-bit control/status registers.
- Supersedes the fixed 2x8-bit cache/debug control file.
- Each bit is typed per parameter mask as RW, RO, W1C or SC (self-clearing pulse).
- Registered single-beat response with error signalling, sticky event capture and an interrupt output; sits on the data-side Wishbone interconnect beside the cache.

Parameters:
- NUM_REGS, 4, number of 32-bit registers (>=2); IDXW = max(1, clog2(NUM_REGS)).
- ADR_BASE, 32'h8000_0000, decode base.
- ADR_MASK, 32'hFFFF_FF00, decode mask; hit = (wb_adr_i & ADR_MASK) == ADR_BASE.
- RW_MASK, {32'h0,32'h0,32'hFFFF_FFFF,32'h0000_0002}, RW bits (reg0 is the right-most word).
- SC_MASK, {32'h0,32'h0,32'h0,32'h0000_0001}, self-clearing bits.
- W1C_MASK, {32'h0,32'h0000_00FF,32'h0,32'h0}, sticky event bits.
- RO_MASK, {32'hFFFF_FFFF,32'h0,32'h0,32'h0}, bits read from status_i.
- RESET_VAL, all zero, reset value of RW/SC/W1C bits.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_n_i  in  1  asynchronous active-low reset.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  32  byte address.
- wb_sel_i  in  4  byte lane selects.
- wb_dat_i  in  32  write data.
- wb_cti_i  in  3  cycle type.
- wb_bte_i  in  2  burst type, ignored.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge.
- wb_err_o  out  1  error.
- wb_rty_o  out  1  retry, tied 0.
- status_i  in  NUM_REGS*32  values for RO bits.
- event_i  in  NUM_REGS*32  set pulses for W1C bits.
- ctrl_o  out  NUM_REGS*32  current RW/SC/W1C bit values.
- irq_o  out  1  OR of all set W1C bits.

Behaviour:
- Reset: async on wb_rst_n_i low. FSM goes to IDLE; ack/err/dat_o/irq_o = 0; RW/SC/W1C bits = RESET_VAL. Reset mid-transaction drops ack/err immediately and discards any pending response.
- Decode: idx = wb_adr_i[IDXW+1:2]; adr[1:0] ignored.
- Request = cyc & stb & hit. Non-hit addresses get no response, so another slave may answer.
- FSM: IDLE -> RESP on a request. RESP -> IDLE unconditionally. A request is never accepted in RESP, so back-to-back transfers take 2 cycles each. ack or err is high for exactly the one RESP cycle.
- Error: idx >= NUM_REGS, or cti not 3'b000/3'b111. err=1 and ack=0 in RESP; no state change; dat_o = 0.
- Write (accepting edge in IDLE): per byte lane with sel=1:
  - RW bits take the data.
  - SC bits take the data; a written 1 is cleared automatically on the next edge, so ctrl_o shows a one-cycle pulse.
  - W1C bits: a written 1 clears the bit; a written 0 has no effect.
  - RO and reserved bits are ignored.
- sel=0 write: acked, nothing changes.
- Read: data is sampled at the accepting edge and driven on wb_dat_o only during RESP, 0 otherwise. Sampled data is:
  - RW/SC/W1C bits: the register value.
  - RO bits: status_i.
  - reserved bits: 0.
  - wb_sel_i does not mask read data.
- Events: event_i bit=1 sets the W1C bit every cycle, independent of the bus. Set beats clear when both occur on the same edge.
- irq_o: registered, one cycle after any W1C bit changes.
- Mask overlap between RW, SC, W1C and RO is illegal; the design asserts on it in simulation.
- Default map:
  - reg0: bit1 cache_en, bit0 cache_flush pulse.
  - reg1: scratch.
  - reg2[7:0]: events.
  - reg3: status.

Test Plan:
- Write 32'hA5A5_A5A5 to reg1 with sel=4'b0101, then read reg1 -> 32'h00A5_00A5. Ack is one cycle after each request and lasts one cycle; err=0.
- Write 32'h3 to reg0 -> ctrl_o[1:0]=2'b11 for one cycle, then 2'b10. Read reg0 -> 32'h2.
- Pulse event_i[64+3]; read reg2 -> 32'h8 and irq_o=1. Write 32'h8 to reg2 while pulsing event_i[64+3] on the same cycle -> bit stays set. Write 32'h8 again -> bit clears, irq_o=0 one cycle later.
- Set status_i[127:96]=32'hDEAD_BEEF; read reg3 -> DEAD_BEEF. Write 0 to reg3 -> acked, read still returns DEAD_BEEF.
- Access ADR_BASE+32'h10 (idx 4), and reg0 with cti=3'b010 -> err=1 for one cycle, ack=0, registers unchanged. Address 32'h9000_0000 -> no ack, no err.
- Start a read of reg1, then pull wb_rst_n_i low during RESP -> ack drops immediately. After reset, reg0 = 0 and a fresh read succeeds.
